bus_split_router: RTL and testbench

BUS_SPLIT_ROUTER -- requirements
Module: bus_split_router

---
 rtl/bus_split_router.sv | 146 ++++++++++++++
 tb/tb_bus_split_router.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bus_split_router.sv
// rtl/bus_split_router.sv - one master to N slaves, select taken from high address bits.
// The optional slave timeout is enabled by defining BUS_SPLIT_ROUTER_TIMEOUT_EN.
module bus_split_router #(
  parameter int                N_SLAVES    = 3,
  parameter int                P_SLAVES    = 31,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEADBEEF,
  parameter int                TIMEOUT_CYC = 64,
  localparam int               SEL_W       = $clog2(N_SLAVES),
  localparam int               STRB_W      = DATA_W / 8,
  localparam int               REQ_W       = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int               RESP_W      = DATA_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         err,
  output logic                         busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [SEL_W-1:0]    sel_q;
  logic                err_q;

  logic                m_valid;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [STRB_W-1:0]   m_wstrb;
  logic [SEL_W-1:0]    m_sel;
  logic                sel_bad;

  assign {m_valid, m_addr, m_wdata, m_wstrb} = m_req;
  assign m_sel   = m_addr[P_SLAVES -: SEL_W];
  assign sel_bad = {1'b0, m_sel} >= (SEL_W+1)'(N_SLAVES);

  logic                slv_ready;
  logic [DATA_W-1:0]   slv_rdata;

  // Only the captured slave's response is ever looked at.
  always_comb begin
    slv_ready = 1'b0;
    slv_rdata = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        {slv_rdata, slv_ready} = s_resp[k*RESP_W +: RESP_W];
      end
    end
  end

  always_comb begin
    s_req = '0;
    if (state == S_REQ) begin
      for (int k = 0; k < N_SLAVES; k++) begin
        if (sel_q == SEL_W'(k)) begin
          s_req[k*REQ_W +: REQ_W] = {1'b1, addr_q, wdata_q, wstrb_q};
        end
      end
    end
  end

  logic expire;

`ifdef BUS_SPLIT_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Held at zero outside REQ, so every REQ visit starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != S_REQ) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign expire         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m_valid) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            wstrb_q <= m_wstrb;
            sel_q   <= m_sel;
            if (sel_bad) begin
              rdata_q <= ERR_DATA;
              err_q   <= 1'b1;
              state   <= S_RESP;
            end else begin
              err_q   <= 1'b0;
              state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (slv_ready) begin
            rdata_q <= slv_rdata;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (expire) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_resp = (state == S_RESP) ? {rdata_q, 1'b1} : '0;
  assign err    = (state == S_RESP) && err_q;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_bus_split_router.sv
// tb/tb_bus_split_router.sv - directed and random transactions against a per-transaction timing model.
module tb_bus_split_router;

  localparam int N  = 3;
  localparam int RW = 69;
  localparam int PW = 33;
  localparam int TO = 4;
`ifdef BUS_SPLIT_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [RW-1:0]   m_req;
  logic [PW-1:0]   m_resp;
  logic [N*RW-1:0] s_req;
  logic [N*PW-1:0] s_resp;
  logic            err;
  logic            busy;

  int          total = 0;
  int          bad   = 0;
  int          wait_c [N];
  logic [31:0] rd     [N];
  bit          noise  [N];
  int          vcnt   [N];

  bus_split_router #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave k raises ready once it has seen valid for wait_c[k] earlier cycles;
  // while unselected it may drive spurious ready (noise).
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      logic rdy;
      if (s_req[k*RW + RW - 1]) begin
        rdy = (vcnt[k] == wait_c[k]);
        vcnt[k] = vcnt[k] + 1;
      end else begin
        vcnt[k] = 0;
        rdy = noise[k];
      end
      s_resp[k*PW +: PW] = {rd[k], rdy};
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pre=1 when the request is presented during the previous transaction's RESP cycle.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                         input int pre, input bit hold);
    int          sel;
    int          vcyc;
    int          lat;
    bit          is_err;
    logic [31:0] exp_rd;
    logic [N*RW-1:0] exp_s;
    sel    = int'(addr >> 30);
    is_err = (sel >= N);
    vcyc   = 0;
    if (!is_err) begin
      if (TO_EN && wait_c[sel] >= TO) begin
        vcyc   = TO;
        is_err = 1'b1;
      end else begin
        vcyc = wait_c[sel] + 1;
      end
    end
    lat    = vcyc + 1;
    exp_rd = is_err ? 32'hDEADBEEF : rd[sel];
    m_req  = {1'b1, addr, wd, ws};
    for (int t = 1 - pre; t <= lat; t++) begin
      @(negedge clk);
      exp_s = '0;
      if (t >= 1 && t <= vcyc) exp_s[sel*RW +: RW] = {1'b1, addr, wd, ws};
      check("s_req", 256'(s_req), 256'(exp_s));
      check("busy", 256'(busy), 256'(t >= 1 && t <= lat));
      check("err", 256'(err), 256'(is_err && t == lat));
      check("m_resp", 256'(m_resp), (t == lat) ? 256'({exp_rd, 1'b1}) : 256'(0));
    end
    if (!hold) begin
      m_req = '0;
      @(negedge clk);
      check("idle_after", 256'({busy, err, m_resp}), 256'(0));
      check("idle_s_req", 256'(s_req), 256'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_hold;
    rst   = 1'b0;
    m_req = '0;
    for (int k = 0; k < N; k++) begin
      wait_c[k] = 0;
      rd[k]     = 32'h0;
      noise[k]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_s_req", 256'(s_req), 256'(0));
    check("rst_out", 256'({busy, err, m_resp}), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // slave 1 with two wait cycles
    wait_c[1] = 2; rd[1] = 32'h1234_5678;
    run_txn(32'h4000_0010, 32'h0, 4'h0, 0, 1'b0);

    // zero-wait write to slave 0
    wait_c[0] = 0; rd[0] = 32'h0BAD_F00D;
    run_txn(32'h0000_0004, 32'hA5A5_A5A5, 4'hF, 0, 1'b0);

    // unmapped slave select
    run_txn(32'hC000_0000, 32'h1111_2222, 4'h3, 0, 1'b0);

    // valid held through RESP with the next request already waiting
    wait_c[2] = 1; rd[2] = 32'hCAFE_0002;
    run_txn(32'h4000_0010, 32'h0, 4'h0, 0, 1'b1);
    run_txn(32'h8000_0000, 32'h7777_8888, 4'h5, 1, 1'b0);

    // reset in the second REQ cycle
    wait_c[1] = 3; rd[1] = 32'h5555_AAAA;
    m_req = {1'b1, 32'h4000_0020, 32'h0, 4'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_s_req", 256'(s_req), 256'(0));
    check("mid_rst_out", 256'({busy, err, m_resp}), 256'(0));
    m_req = '0;
    repeat (3) begin
      @(negedge clk);
      check("in_rst_out", 256'({busy, err, m_resp}), 256'(0));
    end
    rst = 1'b1;
    run_txn(32'h4000_0020, 32'h9, 4'h1, 0, 1'b0);

`ifdef BUS_SPLIT_ROUTER_TIMEOUT_EN
    // silent slave, with a late ready once valid has dropped
    wait_c[0] = 100; noise[0] = 1'b1;
    run_txn(32'h0000_0100, 32'h3, 4'h2, 0, 1'b0);
    noise[0] = 1'b0;
`endif

    prev_hold = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      bit          h;
      for (int k = 0; k < N; k++) begin
        wait_c[k] = $urandom_range(0, 4);
        rd[k]     = $urandom;
        noise[k]  = 1'($urandom_range(0, 1));
      end
      a = {2'($urandom_range(0, 3)), 30'($urandom)};
      h = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      run_txn(a, $urandom, 4'($urandom), prev_hold ? 1 : 0, h);
      prev_hold = h;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
